icache_ctrl: RTL and testbench

- Direct-mapped L1 instruction cache controller: the responder end of the fetch-to-I-cache request/response channel; drop-in replacement for the fixed-content ROM model.
- Serves fetch with 1-cycle hit latency, back-to-back.
- On a miss, refills one line from a memory-side burst port, then replays the lookup.
- Supports kill (redirect, drop the outstanding response) and flush (invalidate all lines).

---
 rtl/icache_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_icache_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped L1 instruction cache controller: 1-cycle back-to-back hits,
// single-line burst refill with lookup replay, pipeline kill and full flush.
module icache_ctrl #(
    parameter int ADDR       = 32,
    parameter int INST       = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    input  logic [ADDR-1:0]   i_req_addr,
    output logic              o_req_ready,
    output logic              o_resp_valid,
    output logic [ADDR-1:0]   o_resp_addr,
    output logic [INST-1:0]   o_resp_inst,
    input  logic              i_kill,
    input  logic              i_flush,
    output logic              o_mem_req_valid,
    output logic [ADDR-1:0]   o_mem_req_addr,
    input  logic              i_mem_req_ready,
    input  logic              i_mem_resp_valid,
    input  logic [INST-1:0]   i_mem_resp_data
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int OFF_BITS  = WORD_BITS + 2;
    localparam int TAG_BITS  = ADDR - OFF_BITS - IDX_BITS;
    localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SETS-1:0]      r_valid;
    logic [TAG_BITS-1:0]  r_tag  [SETS];
    logic [INST-1:0]      r_data [SETS][LINE_WORDS];
    logic [ADDR-1:0]      r_addr;
    logic [WORD_BITS-1:0] r_cnt;
    logic                 r_killed;
    logic                 r_flush_pend;

    logic [IDX_BITS-1:0]  w_idx;
    logic [WORD_BITS-1:0] w_word;
    logic [TAG_BITS-1:0]  w_tag;
    logic                 w_hit;
    logic                 w_beat;
    logic                 w_last_beat;
    logic                 w_req_ready;
    logic                 w_resp_valid;
    logic                 w_mem_req_valid;
    logic                 w_accept;
    logic                 w_enter_idle;
    logic                 w_clear_all;

    // All lookups and refills work on the registered request address.
    assign w_idx       = r_addr[OFF_BITS +: IDX_BITS];
    assign w_word      = r_addr[2 +: WORD_BITS];
    assign w_tag       = r_addr[ADDR-1 -: TAG_BITS];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_beat      = (r_state == REFILL) && i_mem_resp_valid;
    assign w_last_beat = w_beat && (r_cnt == LAST_BEAT);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
        w_next          = r_state;
        w_req_ready     = 1'b0;
        w_resp_valid    = 1'b0;
        w_mem_req_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = !i_kill && !i_flush;
                if (i_req_valid && w_req_ready) begin
                    w_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (i_kill) begin
                    w_next = IDLE;
                end else if (w_hit) begin
                    w_resp_valid = 1'b1;
                    w_req_ready  = 1'b1;
                    w_next       = i_req_valid ? LOOKUP : IDLE;
                end else begin
                    w_next = MISS_REQ;
                end
            end
            MISS_REQ: begin
                w_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    w_next = REFILL;
                end else if (i_kill) begin
                    w_next = IDLE;
                end
            end
            REFILL: begin
                if (w_last_beat) begin
                    w_next = (r_killed || i_kill) ? IDLE : LOOKUP;
                end
            end
            default: w_next = IDLE;
        endcase
        // Outputs stay quiet for the whole reset cycle, whatever state was left behind.
        if (i_reset) begin
            w_next          = IDLE;
            w_req_ready     = 1'b0;
            w_resp_valid    = 1'b0;
            w_mem_req_valid = 1'b0;
        end
    end

    assign w_accept     = i_req_valid && w_req_ready;
    assign w_enter_idle = (w_next == IDLE) && (r_state != IDLE);
    // Flush in IDLE clears at once; elsewhere it waits for the return to IDLE.
    assign w_clear_all  = ((r_state == IDLE) && i_flush) ||
                          (w_enter_idle && (r_flush_pend || i_flush));

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_killed     <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= i_req_addr;
            end
            if ((r_state == MISS_REQ) && i_mem_req_ready) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_last_beat) begin
                r_valid[w_idx] <= 1'b1;
            end
            if (w_clear_all) begin
                r_valid <= '0;
            end
            if (w_next == IDLE) begin
                r_killed <= 1'b0;
            end else if (i_kill && ((r_state == REFILL) ||
                                    ((r_state == MISS_REQ) && i_mem_req_ready))) begin
                r_killed <= 1'b1;
            end
            if (w_next == IDLE) begin
                r_flush_pend <= 1'b0;
            end else if (i_flush && (r_state != IDLE)) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether their contents are used.
    always_ff @(posedge i_clk) begin
        if (w_beat && !i_reset) begin
            r_data[w_idx][r_cnt] <= i_mem_resp_data;
            if (w_last_beat) begin
                r_tag[w_idx] <= w_tag;
            end
        end
    end

    assign o_req_ready     = w_req_ready;
    assign o_resp_valid    = w_resp_valid;
    assign o_resp_addr     = w_resp_valid ? r_addr : '0;
    assign o_resp_inst     = w_resp_valid ? r_data[w_idx][w_word] : '0;
    assign o_mem_req_valid = w_mem_req_valid;
    assign o_mem_req_addr  = w_mem_req_valid ? {r_addr[ADDR-1:OFF_BITS], {OFF_BITS{1'b0}}} : '0;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus a randomized
// request stream checked against a line-level cache and memory model.
module tb_icache_ctrl;

    localparam int ADDR = 32;
    localparam int INST = 32;
    localparam int LW   = 4;
    localparam int SETS = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic [ADDR-1:0]   req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [ADDR-1:0]   resp_addr;
    logic [INST-1:0]   resp_inst;
    logic              kill;
    logic              flush;
    logic              mem_req_valid;
    logic [ADDR-1:0]   mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [INST-1:0]   mem_resp_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icache_ctrl #(.ADDR(ADDR), .INST(INST), .LINE_WORDS(LW), .SETS(SETS)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_req_valid      (req_valid),
        .i_req_addr       (req_addr),
        .o_req_ready      (req_ready),
        .o_resp_valid     (resp_valid),
        .o_resp_addr      (resp_addr),
        .o_resp_inst      (resp_inst),
        .i_kill           (kill),
        .i_flush          (flush),
        .o_mem_req_valid  (mem_req_valid),
        .o_mem_req_addr   (mem_req_addr),
        .i_mem_req_ready  (mem_req_ready),
        .i_mem_resp_valid (mem_resp_valid),
        .i_mem_resp_data  (mem_resp_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: memory image plus what each cache set currently holds.
    logic [31:0] mem_pre [logic [31:0]];
    bit          mvalid [SETS];
    logic [31:0] mtag   [SETS];
    logic [31:0] mline  [SETS][LW];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_pre.exists(a)) return mem_pre[a];
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a / 16) % SETS;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(a / 4) % LW;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a - (a % 16);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mvalid[idx_of(a)] && (mtag[idx_of(a)] == a / 1024);
    endfunction

    function automatic logic [31:0] model_inst(input logic [31:0] a);
        return mline[idx_of(a)][word_of(a)];
    endfunction

    task automatic model_fill(input logic [31:0] a);
        for (int w = 0; w < LW; w++) mline[idx_of(a)][w] = mem_word(line_of(a) + 4 * w);
        mvalid[idx_of(a)] = 1'b1;
        mtag[idx_of(a)]   = a / 1024;
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++) mvalid[s] = 1'b0;
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        check("issue_req_ready", req_ready, 1);
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic handshake(input logic [31:0] a, input int ready_dly);
        for (int d = 0; d < ready_dly; d++) begin
            #1;
            check("mreq_valid_wait", mem_req_valid, 1);
            check("mreq_addr_wait", mem_req_addr, line_of(a));
            cyc();
        end
        mem_req_ready = 1'b1;
        #1;
        check("mreq_valid", mem_req_valid, 1);
        check("mreq_addr", mem_req_addr, line_of(a));
        cyc();
        mem_req_ready = 1'b0;
    endtask

    task automatic beat(input logic [31:0] a, input int w);
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_word(line_of(a) + 4 * w);
        #1;
        check("refill_no_resp", resp_valid, 0);
        check("refill_no_mreq", mem_req_valid, 0);
        cyc();
        mem_resp_valid = 1'b0;
    endtask

    task automatic refill(input logic [31:0] a, input int ready_dly, input int gap_max);
        handshake(a, ready_dly);
        for (int w = 0; w < LW; w++) begin
            int gaps;
            gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int g = 0; g < gaps; g++) begin
                #1;
                check("gap_no_resp", resp_valid, 0);
                cyc();
            end
            beat(a, w);
        end
        model_fill(a);
    endtask

    // Response cycle for address a; optionally offers the next request in the same cycle.
    task automatic lookup_resp(input logic [31:0] a, input bit chain, input logic [31:0] nxt);
        if (chain) begin
            req_valid = 1'b1;
            req_addr  = nxt;
        end
        #1;
        check("resp_valid", resp_valid, 1);
        check("resp_addr", resp_addr, a);
        check("resp_inst", resp_inst, model_inst(a));
        check("hit_no_mreq", mem_req_valid, 0);
        if (chain) check("chain_req_ready", req_ready, 1);
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic access(input logic [31:0] a, input bit chained_in, input bit chain,
                          input logic [31:0] nxt, input int ready_dly, input int gap_max);
        if (!chained_in) issue(a);
        if (!model_hit(a)) begin
            #1;
            check("miss_no_resp", resp_valid, 0);
            check("miss_not_ready", req_ready, 0);
            cyc();
            refill(a, ready_dly, gap_max);
        end
        lookup_resp(a, chain, nxt);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_addr"}, resp_addr, 0);
        check({tag, "_resp_inst"}, resp_inst, 0);
        check({tag, "_mreq_valid"}, mem_req_valid, 0);
        check({tag, "_mreq_addr"}, mem_req_addr, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addrs [400];

        reset          = 1'b1;
        req_valid      = 1'b1;
        req_addr       = 32'h0000_1004;
        kill           = 1'b0;
        flush          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        for (int w = 0; w < LW; w++) begin
            mem_pre[32'h1000 + 4 * w] = 32'hA0 + w;
            mem_pre[32'h1400 + 4 * w] = 32'hB0 + w;
            mem_pre[32'h2000 + 4 * w] = 32'hC0 + w;
        end
        model_flush();

        // Reset: outputs held at zero even with a request pending.
        @(negedge clk);
        cyc();
        #1;
        check_quiet("reset");
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check("post_reset_ready", req_ready, 1);
        check("post_reset_resp", resp_valid, 0);

        // Cold miss with back-to-back beats.
        access(32'h1004, 0, 0, 0, 0, 0);

        // Back-to-back hits on the filled line.
        access(32'h1000, 0, 1, 32'h1008, 0, 0);
        access(32'h1008, 1, 1, 32'h100C, 0, 0);
        access(32'h100C, 1, 0, 0, 0, 0);

        // Conflict eviction in set 0, then the evicted line misses again.
        access(32'h1400, 0, 0, 0, 1, 1);
        check("evict_model_miss", model_hit(32'h1000), 0);
        access(32'h1000, 0, 0, 0, 0, 0);

        // Kill with beat 1: refill completes silently, line is still usable.
        issue(32'h2000);
        #1;
        check("kill_lookup_miss", resp_valid, 0);
        cyc();
        handshake(32'h2000, 0);
        for (int w = 0; w < LW; w++) begin
            kill = (w == 1);
            beat(32'h2000, w);
            kill = 1'b0;
        end
        #1;
        check("kill_no_resp", resp_valid, 0);
        check("kill_back_idle", req_ready, 1);
        model_fill(32'h2000);
        access(32'h2004, 0, 0, 0, 0, 0);

        // Flush during refill: replay still answers, everything invalid afterwards.
        issue(32'h3000);
        #1;
        check("flush_lookup_miss", resp_valid, 0);
        cyc();
        handshake(32'h3000, 0);
        for (int w = 0; w < LW; w++) begin
            flush = (w == 0);
            beat(32'h3000, w);
            flush = 1'b0;
        end
        model_fill(32'h3000);
        lookup_resp(32'h3000, 0, 0);
        model_flush();
        access(32'h3000, 0, 0, 0, 0, 0);
        access(32'h1008, 0, 0, 0, 0, 0);

        // Reset after beat 1; stray beats are ignored and the cache is cold.
        issue(32'h5000);
        #1;
        check("rst_lookup_miss", resp_valid, 0);
        cyc();
        handshake(32'h5000, 0);
        beat(32'h5000, 0);
        beat(32'h5000, 1);
        reset = 1'b1;
        #1;
        check_quiet("midreset");
        cyc();
        reset = 1'b0;
        model_flush();
        for (int w = 2; w < LW; w++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD_0000 + w;
            #1;
            check("stray_no_resp", resp_valid, 0);
            check("stray_no_mreq", mem_req_valid, 0);
            cyc();
        end
        mem_resp_valid = 1'b0;
        access(32'h1004, 0, 0, 0, 0, 0);

        // Randomized stream over a small set/tag pool to mix hits, misses and evictions.
        for (int i = 0; i < 400; i++) begin
            addrs[i] = 32'h8000_0000 + $urandom_range(0, 3) * 1024
                     + $urandom_range(0, 7) * 16 + $urandom_range(0, 15);
        end
        begin
            bit chained;
            chained = 1'b0;
            for (int i = 0; i < 400; i++) begin
                bit chain;
                if (!chained && ($urandom_range(0, 11) == 0)) begin
                    flush     = 1'b1;
                    req_valid = 1'b1;
                    req_addr  = addrs[i];
                    #1;
                    check("flush_idle_not_ready", req_ready, 0);
                    cyc();
                    flush     = 1'b0;
                    req_valid = 1'b0;
                    model_flush();
                end
                chain = (i < 399) && ($urandom_range(0, 1) == 1);
                access(addrs[i], chained, chain, (i < 399) ? addrs[i + 1] : 32'h0,
                       int'($urandom_range(0, 2)), 2);
                chained = chain;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
